baud_cfg_controller: RTL
========================

// Module: baud_cfg_controller
// PURPOSE
//   Sequences divisor (M) updates into baud_rate_generator. AXI-lite writes a new
//   divisor; block holds it in a shadow register, waits until TX and RX are idle,
//   loads M, clears the generator, confirms with the first new tick. Also divides
//   the oversample tick into a per-bit tick for the UART datapath.
// PARAMETERS
//   DEFAULT_DIV     651        M after reset (100 MHz / (9600*16))
//   MIN_DIV         2          smallest legal divisor; smaller writes rejected
//   OVERSAMPLE      16         ticks per bit_tick (>=2)
//   TIMEOUT_CYCLES  1000000    PENDING wait limit (BAUD_CFG_TIMEOUT_EN only)
// PORTS
//   clk_100MHz   in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   cfg_wr       in   1   one-cycle write strobe from AXI register file
//   cfg_div      in   16  requested divisor, sampled when cfg_wr=1
//   cfg_ready    out  1   1 in IDLE/PENDING: writes accepted
//   cfg_ack      out  1   one-cycle pulse: new divisor live
//   cfg_err      out  1   one-cycle pulse: write rejected
//   cfg_pending  out  1   1 while a divisor waits to be applied
//   cfg_timeout  out  1   one-cycle pulse: forced apply after timeout
//   tx_busy      in   1   transmitter mid-frame
//   rx_busy      in   1   receiver mid-frame
//   tick         in   1   oversample tick from baud_rate_generator
//   M            out  16  divisor to baud_rate_generator
//   gen_clr      out  1   one-cycle registered clear, ORed into generator reset
//   bit_tick     out  1   one-cycle pulse every OVERSAMPLE ticks
// BEHAVIOUR
//   Reset: state=IDLE, M=DEFAULT_DIV, shadow=DEFAULT_DIV, os_cnt=0; cfg_ack,
//     cfg_err, cfg_timeout, gen_clr, bit_tick=0; cfg_pending=0; cfg_ready=1.
//   All outputs registered; pulses last exactly one cycle.
//   Write check: cfg_div<MIN_DIV, or cfg_wr with cfg_ready=0 -> cfg_err next
//     cycle; shadow and state unchanged.
//   FSM:
//   IDLE: valid cfg_wr -> shadow<=cfg_div. If cfg_div==M: cfg_ack next cycle,
//     stay IDLE. Else -> PENDING.
//   PENDING: cfg_pending=1. Valid cfg_wr overwrites shadow (last write wins);
//     no extra ack. If tx_busy=0 and rx_busy=0 in a cycle with no cfg_wr
//     -> APPLY. cfg_wr in the same cycle takes priority; re-evaluate next cycle.
//     Write returning shadow to M still goes through APPLY.
//   APPLY (1 cycle): M<=shadow, gen_clr<=1, os_cnt<=0, cfg_pending<=0; tick
//     ignored. -> SETTLE.
//   SETTLE: cfg_ready=0. First tick -> cfg_ack next cycle, -> IDLE. This tick
//     counts toward os_cnt.
//   Latency: idle link, write at cycle 0 -> PENDING 1 -> APPLY 2 (M, gen_clr
//     visible 3) -> ack one cycle after the first tick, about M+4 cycles.
//   bit_tick: on tick outside APPLY: os_cnt==OVERSAMPLE-1 -> os_cnt<=0,
//     bit_tick<=1; else os_cnt+1. os_cnt width $clog2(OVERSAMPLE).
//   busy rising during PENDING after APPLY has started: no effect; apply runs
//     to completion.
//   Async reset at any time: immediate return to reset values; shadow discarded.
// CONFIGURATION
//   BAUD_CFG_TIMEOUT_EN defined: PENDING counts cycles from entry (restarts on
//     each valid cfg_wr). At TIMEOUT_CYCLES-1 with busy still set: forced APPLY,
//     cfg_timeout pulse in the APPLY cycle.
//   Undefined: PENDING waits for idle indefinitely; no counter logic; cfg_timeout
//     tied 0.
// TESTING
//   Reset release -> M=651, cfg_ready=1; ticks every 651 cycles;
//     bit_tick every 16 ticks.
//   Idle link, cfg_wr div=10 -> PENDING 1 cycle, gen_clr 1 cycle, M=10;
//     cfg_ack one cycle after first tick; tick period then 10.
//   tx_busy=1, write div=20 -> stays PENDING, M=651; tx_busy falls ->
//     APPLY next cycle, M=20.
//   In PENDING write 20 then 30, then release busy -> M=30, single cfg_ack.
//   cfg_div=1, or write during SETTLE -> cfg_err pulse; M and state unchanged.
//   BAUD_CFG_TIMEOUT_EN with TIMEOUT_CYCLES=100, rx_busy held 1 -> forced APPLY
//     100 cycles after PENDING entry; cfg_timeout pulse; new M.

Source files
------------

// File: rtl/baud_cfg_controller.sv
// Divisor update sequencer for the baud rate generator, plus tick-to-bit_tick divider.
// Optional PENDING timeout enabled with `define BAUD_CFG_TIMEOUT_EN.
module baud_cfg_controller #(
  parameter int DEFAULT_DIV    = 651,
  parameter int MIN_DIV        = 2,
  parameter int OVERSAMPLE     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_div,
  output logic        cfg_ready,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        cfg_pending,
  output logic        cfg_timeout,
  input  logic        tx_busy,
  input  logic        rx_busy,
  input  logic        tick,
  output logic [15:0] M,
  output logic        gen_clr,
  output logic        bit_tick
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);
  localparam logic [15:0] DIV_MIN = 16'(MIN_DIV);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY, SETTLE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       shadow;
  logic [OS_W-1:0]   os_cnt;
  logic              wr_ok, load_shadow, ack_nxt, timeout_nxt;

  // A write is only legal while the controller advertises ready.
  assign wr_ok = cfg_wr && cfg_ready && (cfg_div >= DIV_MIN);

`ifdef BAUD_CFG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      cfg_timeout <= 1'b0;
    end else begin
      cfg_timeout <= timeout_nxt;
      if (state != PENDING || wr_ok)
        to_cnt <= '0;
      else if (!to_hit)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic to_hit;
  assign to_hit      = 1'b0;
  assign cfg_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    load_shadow = 1'b0;
    ack_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok) begin
          load_shadow = 1'b1;
          if (cfg_div == M) ack_nxt = 1'b1;
          else              state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (wr_ok) begin
          load_shadow = 1'b1;
        end else if (!cfg_wr) begin
          if (!tx_busy && !rx_busy) begin
            state_nxt = APPLY;
          end else if (to_hit) begin
            state_nxt   = APPLY;
            timeout_nxt = 1'b1;
          end
        end
      end
      APPLY:   state_nxt = SETTLE;
      SETTLE: begin
        if (tick) begin
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= DIV_RST;
      M           <= DIV_RST;
      os_cnt      <= '0;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      gen_clr     <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cfg_ready   <= (state_nxt == IDLE) || (state_nxt == PENDING);
      cfg_pending <= (state_nxt == PENDING);
      cfg_ack     <= ack_nxt;
      cfg_err     <= cfg_wr && !wr_ok;
      gen_clr     <= (state == APPLY);
      bit_tick    <= 1'b0;
      if (load_shadow) shadow <= cfg_div;
      // The generator restarts from the clear, so the bit phase restarts too.
      if (state == APPLY) begin
        M      <= shadow;
        os_cnt <= '0;
      end else if (tick) begin
        if (os_cnt == OS_LAST) begin
          os_cnt   <= '0;
          bit_tick <= 1'b1;
        end else begin
          os_cnt <= os_cnt + 1'b1;
        end
      end
    end
  end

endmodule
